raizing_gfx_arb: RTL

RAIZING_GFX_ARB -- requirements
Module: raizing_gfx_arb

---
 rtl/raizing_gfx_arb.sv | 124 ++++++++++++
 1 files changed

// File: rtl/raizing_gfx_arb.sv
// raizing_gfx_arb: round-robin share of one ROM port among NCH layer channels; ROM_CS rises one cycle after a channel is pending, CH_OK the cycle after an accepted ROM_OK.
// Stalls only on ROM_OK; define RAIZING_GFX_ARB_CACHE_EN to keep served data valid across CS drops (address-match cache hit).
module raizing_gfx_arb #(
  parameter int NCH = 4,
  parameter int AW  = 22,
  parameter int DW  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NCH-1:0]    CH_CS,
  input  logic [NCH*AW-1:0] CH_ADDR,
  output logic [NCH-1:0]    CH_OK,
  output logic [NCH*DW-1:0] CH_DATA,
  output logic              ROM_CS,
  output logic [AW-1:0]     ROM_ADDR,
  input  logic [DW-1:0]     ROM_DOUT,
  input  logic              ROM_OK,
  output logic [2:0]        BUSY_CH
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      gnt_q, last_q, gnt_idx;
  logic            gnt_vld;
  logic            first_q;
  logic            accept;
  logic [AW-1:0]   gnt_addr;
  logic [NCH-1:0]  valid_q, hit, pending;
  logic [AW-1:0]   srv_addr [NCH];
  logic [NCH*DW-1:0] data_q;

  assign CH_DATA = data_q;

  always_comb begin
    hit = '0;
    for (int n = 0; n < NCH; n++)
      hit[n] = valid_q[n] && (CH_ADDR[n*AW +: AW] == srv_addr[n]);
  end

  assign CH_OK = CH_CS & hit;

`ifdef RAIZING_GFX_ARB_CACHE_EN
  assign pending = CH_CS & ~CH_OK & ~hit;
`else
  assign pending = CH_CS & ~CH_OK;
`endif

  // Search starts one past the last grant and wraps once around all channels.
  always_comb begin
    int c;
    c       = 0;
    gnt_vld = 1'b0;
    gnt_idx = 3'd0;
    for (int i = 1; i <= NCH; i++) begin
      c = int'(last_q) + i;
      if (c >= NCH) c = c - NCH;
      if (!gnt_vld && pending[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = 3'(c);
      end
    end
  end

  always_comb begin
    gnt_addr = '0;
    for (int i = 0; i < NCH; i++)
      if (gnt_idx == 3'(i)) gnt_addr = CH_ADDR[i*AW +: AW];
  end

  // A ROM_OK left high from the previous access must not complete this one.
  assign accept = (state == REQ) && !first_q && ROM_OK;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = REQ;
      REQ:     if (accept)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ROM_CS  = (state == REQ);
    BUSY_CH = (state == IDLE) ? 3'd0 : gnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ROM_ADDR <= '0;
      gnt_q    <= 3'd0;
      last_q   <= 3'(NCH - 1);
      first_q  <= 1'b0;
      valid_q  <= '0;
      data_q   <= '0;
      for (int n = 0; n < NCH; n++) srv_addr[n] <= '0;
    end else begin
      first_q <= 1'b0;
      if (state == IDLE && gnt_vld) begin
        ROM_ADDR <= gnt_addr;
        gnt_q    <= gnt_idx;
        last_q   <= gnt_idx;
        first_q  <= 1'b1;
      end
      for (int n = 0; n < NCH; n++) begin
`ifndef RAIZING_GFX_ARB_CACHE_EN
        if (!CH_CS[n]) valid_q[n] <= 1'b0;
`endif
        if (accept && gnt_q == 3'(n)) begin
          data_q[n*DW +: DW] <= ROM_DOUT;
          srv_addr[n]        <= ROM_ADDR;
          valid_q[n]         <= 1'b1;
        end
      end
    end
  end

endmodule
